// File: rtl/tm1638_pkg.sv
// Shared TM1638 definitions: command bytes, scan FSM states, pad bundle and key map.
package tm1638_pkg;

  localparam logic [7:0] CMD_DISP_MODE  = 8'h8F;
  localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
  localparam logic [7:0] CMD_ADDR       = 8'hC0;
  localparam logic [7:0] CMD_KEY_READ   = 8'h42;

  localparam int unsigned CMD_TICKS  = 16;
  localparam int unsigned READ_TICKS = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_START,
    ST_CMD,
    ST_TURN,
    ST_READ,
    ST_STOP
  } tm1638_state_e;

  typedef struct packed {
    logic stb;
    logic sclk;
    logic dio_out;
    logic dio_oe;
  } tm1638_pins_t;

  localparam tm1638_pins_t PINS_IDLE = '{stb: 1'b1, sclk: 1'b1, dio_out: 1'b1, dio_oe: 1'b0};

  // Keys live in bits 0 and 4 of each of the four scan bytes.
  function automatic logic [7:0] key_map(input logic [31:0] raw);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = raw[8*i];
      k[i + 4] = raw[8*i + 4];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_bitio.sv
// Two-tick-per-bit shifter: holds the transmit LSB across a bit and shifts in DIO on odd phases.
module tm1638_bitio (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_byte_i,
  input  logic       tx_en_i,
  input  logic       rx_en_i,
  input  logic       odd_i,
  input  logic       din_i,
  output logic       tx_bit_c,
  output logic [7:0] rx_byte_c
);

  logic [7:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (tick_i) begin
      if (load_i) begin
        sr_d = load_byte_i;
      end else if (tx_en_i && odd_i) begin
        sr_d = {1'b0, sr_q[7:1]};
      end else if (rx_en_i && odd_i) begin
        sr_d = {din_i, sr_q[7:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Next-value view lets the caller register pad outputs in step with the shift.
  assign tx_bit_c  = sr_d[0];
  assign rx_byte_c = sr_d;

endmodule

// File: rtl/tm1638_keys.sv
// TM1638 key-scan reader: polls, requests the shared bus, reads four key bytes, publishes keys.
// Optional TM1638_KEYS_DEBOUNCE_EN requires two matching scans before keys changes.
module tm1638_keys
  import tm1638_pkg::*;
#(
  parameter int unsigned POLL_TICKS = 10000,
  parameter int unsigned WAIT_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        tm1638_stb,
  output logic        tm1638_clk,
  output logic        tm1638_dio_out,
  output logic        tm1638_dio_oe,
  input  logic        tm1638_dio_in,
  output logic [7:0]  keys,
  output logic [31:0] scan_raw,
  output logic        keys_changed
);

  localparam int unsigned POLL_W = $clog2(POLL_TICKS);
  localparam int unsigned CNT_W  = $clog2((WAIT_TICKS > READ_TICKS) ? WAIT_TICKS : READ_TICKS) + 1;

  tm1638_state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       scan_raw_q, scan_raw_d;
  logic [7:0]        keys_q, keys_d;
  logic              keys_changed_q, keys_changed_d;
  logic              bus_req_q, bus_req_d;
  tm1638_pins_t      pins_q, pins_d;
`ifdef TM1638_KEYS_DEBOUNCE_EN
  logic [7:0]        cand_q, cand_d;
`endif

  logic       load_c, tx_en_c, rx_en_c;
  logic       tx_bit_c;
  logic [7:0] rx_byte_c;
  logic [7:0] new_keys_c;

  assign new_keys_c = key_map(acc_q);

  tm1638_bitio u_bitio (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_i      (clken),
    .load_i      (load_c),
    .load_byte_i (CMD_KEY_READ),
    .tx_en_i     (tx_en_c),
    .rx_en_i     (rx_en_c),
    .odd_i       (cnt_q[0]),
    .din_i       (tm1638_dio_in),
    .tx_bit_c    (tx_bit_c),
    .rx_byte_c   (rx_byte_c)
  );

  // Scan sequencing, byte assembly and key update.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    poll_d         = poll_q;
    acc_d          = acc_q;
    scan_raw_d     = scan_raw_q;
    keys_d         = keys_q;
    keys_changed_d = 1'b0;
`ifdef TM1638_KEYS_DEBOUNCE_EN
    cand_d         = cand_q;
`endif
    load_c  = 1'b0;
    tx_en_c = 1'b0;
    rx_en_c = 1'b0;
    if (clken) begin
      unique case (state_q)
        ST_IDLE: begin
          if (poll_q == POLL_W'(POLL_TICKS - 1)) begin
            poll_d  = '0;
            state_d = ST_REQ;
          end else begin
            poll_d = poll_q + POLL_W'(1);
          end
        end
        ST_REQ: begin
          if (bus_gnt) state_d = ST_START;
        end
        ST_START: begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_CMD;
        end
        ST_CMD: begin
          tx_en_c = 1'b1;
          if (cnt_q == CNT_W'(CMD_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = ST_TURN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_TURN: begin
          if (cnt_q == CNT_W'(WAIT_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = ST_READ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_READ: begin
          rx_en_c = 1'b1;
          if (cnt_q[0] && (cnt_q[3:1] == 3'd7)) acc_d = {rx_byte_c, acc_q[31:8]};
          if (cnt_q == CNT_W'(READ_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STOP: begin
          state_d    = ST_IDLE;
          scan_raw_d = acc_q;
`ifdef TM1638_KEYS_DEBOUNCE_EN
          cand_d = new_keys_c;
          if ((new_keys_c == cand_q) && (new_keys_c != keys_q)) begin
            keys_d         = new_keys_c;
            keys_changed_d = 1'b1;
          end
`else
          keys_d         = new_keys_c;
          keys_changed_d = (new_keys_c != keys_q);
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pad and request values for the state being entered, so the registers track the FSM.
  always_comb begin
    pins_d         = PINS_IDLE;
    pins_d.stb     = !(state_d inside {ST_START, ST_CMD, ST_TURN, ST_READ});
    pins_d.sclk    = !((state_d inside {ST_CMD, ST_READ}) && !cnt_d[0]);
    pins_d.dio_oe  = state_d inside {ST_START, ST_CMD};
    pins_d.dio_out = (state_d == ST_CMD) ? tx_bit_c : 1'b1;
    bus_req_d      = state_d inside {ST_REQ, ST_START, ST_CMD, ST_TURN, ST_READ};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      poll_q         <= '0;
      acc_q          <= '0;
      scan_raw_q     <= '0;
      keys_q         <= '0;
      keys_changed_q <= 1'b0;
      bus_req_q      <= 1'b0;
      pins_q         <= PINS_IDLE;
`ifdef TM1638_KEYS_DEBOUNCE_EN
      cand_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      poll_q         <= poll_d;
      acc_q          <= acc_d;
      scan_raw_q     <= scan_raw_d;
      keys_q         <= keys_d;
      keys_changed_q <= keys_changed_d;
      bus_req_q      <= bus_req_d;
      pins_q         <= pins_d;
`ifdef TM1638_KEYS_DEBOUNCE_EN
      cand_q         <= cand_d;
`endif
    end
  end

  assign bus_req        = bus_req_q;
  assign tm1638_stb     = pins_q.stb;
  assign tm1638_clk     = pins_q.sclk;
  assign tm1638_dio_out = pins_q.dio_out;
  assign tm1638_dio_oe  = pins_q.dio_oe;
  assign keys           = keys_q;
  assign scan_raw       = scan_raw_q;
  assign keys_changed   = keys_changed_q;

endmodule

// File: tb/tb_tm1638_keys.sv
// Bench for tm1638_keys: TM1638 device model, random arbiter delay, scoreboard of scan results.
`timescale 1ns/1ps
module tb_tm1638_keys;

  localparam int unsigned POLL     = 100;
  localparam int unsigned WAITT    = 2;
  localparam int unsigned SCAN_LOW = 1 + 16 + WAITT + 64;

  typedef struct {
    logic [31:0] raw;
    logic [7:0]  keys;
    int          pulses;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clken = 1'b0;
  logic        bus_gnt = 1'b0;
  logic        dio_in = 1'b1;
  logic        bus_req, stb, sclk, dio_out, dio_oe, keys_changed;
  logic [7:0]  keys;
  logic [31:0] scan_raw;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  logic [31:0] resp = '0;
  logic [7:0]  cmd_byte = '0;
  int          fe = 0;
  int          re = 0;
  bit          hold_gnt = 1'b1;
  bit          aborted = 1'b0;
  int          nogrant_viol = 0;
  logic [7:0]  m_keys = '0;
  logic [7:0]  m_cand = '0;

  tm1638_keys #(.POLL_TICKS(POLL), .WAIT_TICKS(WAITT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clken          (clken),
    .bus_req        (bus_req),
    .bus_gnt        (bus_gnt),
    .tm1638_stb     (stb),
    .tm1638_clk     (sclk),
    .tm1638_dio_out (dio_out),
    .tm1638_dio_oe  (dio_oe),
    .tm1638_dio_in  (dio_in),
    .keys           (keys),
    .scan_raw       (scan_raw),
    .keys_changed   (keys_changed)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait expired, got timeout, expected event", name);
  endtask

  // Tick generator; each tick also samples pad state for scan-shape checks.
  initial begin : tick_gen
    int  ph = 0;
    int  low_run = 0;
    int  turn_cnt = 0;
    bit  saw_oe = 1'b0;
    bit  turn_done = 1'b0;
    logic prev_stb = 1'b1;
    forever begin
      @(negedge clk);
      if (clken) begin
        if (!stb) begin
          if (prev_stb) begin
            low_run = 0; turn_cnt = 0; saw_oe = 1'b0; turn_done = 1'b0;
          end
          low_run++;
          if (dio_oe) saw_oe = 1'b1;
          else if (saw_oe && !turn_done) begin
            if (sclk) turn_cnt++;
            else turn_done = 1'b1;
          end
        end else if (!prev_stb && !aborted) begin
          chk("stb_low_ticks", 32'(low_run), 32'(SCAN_LOW));
          chk("turn_release_ticks", 32'(turn_cnt), 32'(WAITT));
        end
        if (hold_gnt && bus_req && !(stb && sclk && !dio_oe)) nogrant_viol++;
        prev_stb = stb;
      end
      ph = (ph + 1) % 4;
      clken = (ph == 3);
    end
  end

  // TM1638 model: captures the command on rising CLK, drives key bits after falling CLK.
  initial begin : device
    logic p_stb = 1'b1;
    logic p_clk = 1'b1;
    forever begin
      @(negedge clk);
      if (p_stb && !stb) begin
        fe = 0; re = 0; cmd_byte = '0;
      end
      if (!stb && p_clk && !sclk) begin
        fe++;
        if (fe >= 9 && fe <= 40) dio_in = resp[5'(fe - 9)];
      end
      if (!stb && !p_clk && sclk && dio_oe && re < 8) begin
        cmd_byte = {dio_out, cmd_byte[7:1]};
        re++;
      end
      p_stb = stb;
      p_clk = sclk;
    end
  end

  // Arbiter: grants after a random delay unless held off, releases when the request drops.
  initial begin : arbiter
    forever begin
      @(negedge clk);
      if (bus_req && !bus_gnt && !hold_gnt) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        if (bus_req) bus_gnt = 1'b1;
      end else if (!bus_req && bus_gnt) begin
        bus_gnt = 1'b0;
      end
    end
  end

  // Scoreboard monitor: each completed scan is compared with the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   pulses;
    logic p_stb = 1'b1;
    forever begin
      @(negedge clk);
      if (!p_stb && stb) begin
        if (!reset_n || aborted) begin
          if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
          pulses = 0;
          for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pulses += int'(keys_changed);
          end
          chk("cmd_byte", 32'(cmd_byte), 32'h42);
          chk("cmd_bits", 32'(re), 32'd8);
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: got unexpected scan, expected none");
          end else begin
            e = sb_q.pop_front();
            chk("scan_raw", scan_raw, e.raw);
            chk("keys", 32'(keys), 32'(e.keys));
            chk("keys_changed_pulses", 32'(pulses), 32'(e.pulses));
          end
        end
      end
      p_stb = stb;
    end
  end

  task automatic count_to_req(output int n);
    n = 0;
    while (!bus_req && n < int'(POLL) + 10) begin
      @(posedge clk);
      if (clken) n++;
      #1;
    end
  endtask

  task automatic run_scan(input logic [31:0] raw, input bit do_reset);
    logic [7:0] k;
    exp_t       e;
    int         t;
    int         n;
    for (int i = 0; i < 4; i++) begin
      k[i]     = ((raw >> (8 * i)) & 32'd1) != 0;
      k[i + 4] = ((raw >> (8 * i + 4)) & 32'd1) != 0;
    end
    e.raw = raw;
    e.pulses = 0;
`ifdef TM1638_KEYS_DEBOUNCE_EN
    if (k == m_cand && k != m_keys) begin
      m_keys = k;
      e.pulses = 1;
    end
    m_cand = k;
`else
    if (k != m_keys) e.pulses = 1;
    m_keys = k;
`endif
    e.keys = m_keys;
    aborted = 1'b0;
    resp = raw;
    sb_q.push_back(e);
    hold_gnt = 1'b0;
    t = 0;
    while (stb && t < 8000) begin @(negedge clk); t++; end
    if (stb) timeout_fail("wait_stb_fall");
    if (do_reset) begin
      t = 0;
      while (fe != 19 && t < 2000) begin @(negedge clk); t++; end
      if (fe != 19) timeout_fail("wait_read_bit10");
      aborted = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("rst_stb", 32'(stb), 32'd1);
      chk("rst_clk", 32'(sclk), 32'd1);
      chk("rst_dio_oe", 32'(dio_oe), 32'd0);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_keys", 32'(keys), 32'd0);
      m_keys = '0;
      m_cand = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      count_to_req(n);
      chk("req_after_abort", 32'(n), 32'(POLL));
    end else begin
      t = 0;
      while (!stb && t < 2000) begin @(negedge clk); t++; end
      if (!stb) timeout_fail("wait_stb_rise");
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin : stim
    int          n;
    logic [31:0] prev;
    logic [31:0] raw;
    logic [31:0] dir [8];
    repeat (5) @(negedge clk);
    chk("reset_bus_req", 32'(bus_req), 32'd0);
    chk("reset_pins", {29'd0, stb, sclk, dio_oe}, 32'b110);
    chk("reset_keys", 32'(keys), 32'd0);
    chk("reset_scan_raw", scan_raw, 32'd0);
    reset_n = 1'b1;
    count_to_req(n);
    chk("req_after_poll", 32'(n), 32'(POLL));
    repeat (1200) @(negedge clk);
    chk("nogrant_pins_idle", 32'(nogrant_viol), 32'd0);
    chk("nogrant_req_held", 32'(bus_req), 32'd1);

    dir[0] = 32'h00100001; dir[1] = 32'h00100001; dir[2] = 32'h0; dir[3] = 32'h0;
    dir[4] = 32'h00000001; dir[5] = 32'h0;        dir[6] = 32'h00000001; dir[7] = 32'h00000001;
    for (int i = 0; i < 8; i++) run_scan(dir[i], 1'b0);

    run_scan($urandom, 1'b1);
    prev = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) raw = prev;
      else raw = $urandom & (($urandom_range(0, 1) == 1) ? 32'h11111111 : 32'hFFFFFFFF);
      run_scan(raw, 1'b0);
      prev = raw;
    end
    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_keys.md
# tm1638_keys

Key-scan reader for the TM1638 LED/key front panel: the read-direction companion to the existing display writer on the same STB/CLK/DIO bus. It periodically requests the shared bus, issues the 0x42 read-key command, turns DIO around, clocks in the four key-scan bytes and publishes an 8-key vector. It sits beside the display writer in the board top; a small top-level arbiter grants the bus to one of the two blocks at a time.

## Interface
- POLL_TICKS, 10000: clken ticks between scan requests (10 ms at 1 MHz); minimum 100.
- WAIT_TICKS, 2: ticks DIO is released after the command, before the first read clock; minimum 2.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- clken  in  1  1 MHz tick; all state advances only on ticks.
- bus_req  out  1  request for the shared TM1638 bus.
- bus_gnt  in  1  grant from the arbiter; held high until bus_req falls.
- tm1638_stb  out  1  strobe, idles 1.
- tm1638_clk  out  1  serial clock, idles 1.
- tm1638_dio_out  out  1  DIO drive value.
- tm1638_dio_oe  out  1  DIO drive enable; the top forms the tristate.
- tm1638_dio_in  in  1  DIO pad input, already synchronised by the top.
- keys  out  8  current key state, 1 = pressed.
- scan_raw  out  32  last four bytes read; byte 0 in bits 7:0.
- keys_changed  out  1  one-clk pulse when keys takes a new value.

## Operation
- Reset values: bus_req 0, tm1638_stb 1, tm1638_clk 1, dio_out 1, dio_oe 0, keys 0, scan_raw 0, keys_changed 0. The poll counter resets to 0 and the FSM resets to IDLE.
- Asserting reset mid-scan aborts immediately. STB and CLK return high and the bus request drops; the TM1638 discards the partial transaction.
- FSM states: IDLE, REQ, START, CMD, TURN, READ, STOP.
- IDLE: the poll counter increments each tick. At POLL_TICKS-1 it clears and the FSM moves to REQ.
- REQ: bus_req=1. The FSM waits for bus_gnt=1 sampled on a tick, then moves to START. There is no timeout.
- START (1 tick): stb=0, dio_oe=1.
- CMD (16 ticks): sends 8'h42 LSB first, 2 ticks per bit.
  - Even tick: clk=0, dio_out=bit.
  - Odd tick: clk=1.
- TURN (WAIT_TICKS ticks): dio_oe=0, clk=1.
- READ (64 ticks): 32 bits, 2 ticks per bit.
  - Even tick: clk=0.
  - Odd tick: clk=1, and tm1638_dio_in is shifted in LSB first.
- STOP (1 tick): stb=1, clk=1, bus_req=0, and the key update runs. The FSM then returns to IDLE and the poll counter restarts from 0.
- Key map: keys[i] = byte i bit 0, and keys[i+4] = byte i bit 4, for i = 0..3. All other bits are kept only in scan_raw.
- bus_gnt dropping while bus_req is high is an arbiter error. The block ignores it and finishes the scan.
- When the block is not granted, its STB/CLK outputs are 1 and dio_oe is 0. The top ANDs STB/CLK with the display writer's outputs.

## Timing
- Scan length from START to STOP is 1+16+WAIT_TICKS+64+1 ticks; 84 ticks at the defaults.
- Scan period is POLL_TICKS plus the grant wait plus the scan length.
- keys, scan_raw and keys_changed update on the STOP tick. keys_changed lasts one clk cycle, not one tick.
- A key press becomes visible within one scan period, or two with debounce enabled.
- DIO is released at least 2 µs before the first read falling edge, meeting the TM1638 Twait requirement.
- The first read falling edge comes ≥1 µs after the turnaround.

## Configuration
- TM1638_KEYS_DEBOUNCE_EN defined:
  - A candidate 8-bit vector is stored each STOP.
  - keys updates only when two consecutive scans produce the same vector and that vector differs from keys.
  - The candidate register resets to 0.
- Undefined: keys takes the mapped vector at every STOP, and keys_changed pulses whenever the value differs.
- scan_raw always updates at every STOP, with or without the macro.

## Structure
- Shared package tm1638_pkg:
  - command constants: display mode 8'h8F, data write 8'h40, address 8'hC0, key read 8'h42
  - the FSM state enum
  - the key-map function from scan bytes to keys
- One sub-module, tm1638_bitio: a 2-tick-per-bit shifter that serialises a byte out on the even/odd phases and deserialises a bit in on the odd phase. The display writer can later reuse it.

## Test plan
- Reset, no grant: after POLL_TICKS ticks bus_req=1, while STB, CLK and dio_oe stay 1/1/0 indefinitely.
- Grant immediately, model returns bytes 01,00,10,00: keys=8'h41, scan_raw=32'h00100001, keys_changed pulses once. Check that the bits on DIO decode to 8'h42 LSB first, and that dio_oe falls before the first read clock.
- Count STB-low duration: exactly 83 ticks at the defaults. Check WAIT_TICKS=2 high-CLK ticks with DIO released.
- Same bytes on two consecutive scans: the second scan produces no keys_changed. An all-zero scan then returns keys to 0 with one pulse.
- Assert reset_n low at read bit 10: STB=1, CLK=1, dio_oe=0 and bus_req=0 immediately. After release the next scan starts only after a full POLL_TICKS.
- With TM1638_KEYS_DEBOUNCE_EN, a one-scan glitch (01,00,00,00 between zeros) leaves keys at 0. Two identical scans set keys=8'h01.
